// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter: registered one-hot grant plus binary index, held until release/disable/timeout.
// Latency: request sampled at an edge in IDLE is granted at that edge; release clears the grant at the sampling edge.
// Backpressure: none; a requester holds its req line for as long as it needs the shared slot.
// Optional hold timeout is compiled in with `define ARB_TIMEOUT_EN (uses MAX_HOLD).
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] owner, owner_nxt;
  logic [7:0] gnt_q, gnt_nxt;
  logic [2:0] idx_q, idx_nxt;
  logic       vld_q, vld_nxt;

  // High when the owner has used up its hold budget this cycle.
  logic       hold_hit;
  // Forced revoke decision for the current edge.
  logic       revoke_to;

  logic [2:0] sel;
  logic       any_req;

  // First set request scanning circularly from the priority pointer.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] pick;
    logic [2:0] cand;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = p + 3'(i);
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign any_req = |req;
  assign sel     = rr_pick(req, ptr);

`ifdef ARB_TIMEOUT_EN
  // Counter value seen during the last allowed grant cycle.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;
  logic       timeout_q;

  assign hold_hit = (hold_cnt == HOLD_LAST);

  // Hold counter: zero whenever idle (so it starts at 0 on each grant), counts grant cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= 8'd0;
    end else if (state == IDLE) begin
      hold_cnt <= 8'd0;
    end else begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  // Timeout pulse lands in the first cycle with the grant cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= revoke_to;
    end
  end

  assign timeout = timeout_q;
`else
  // No hold limit: grants last as long as the owner keeps requesting.
  logic unused_cfg;

  assign hold_hit   = 1'b0;
  assign timeout    = 1'b0;
  assign unused_cfg = ^{8'(MAX_HOLD), revoke_to};
`endif

  // Next-state and next-output decision; disable beats release, release beats timeout.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    gnt_nxt   = gnt_q;
    idx_nxt   = idx_q;
    vld_nxt   = vld_q;
    revoke_to = 1'b0;

    unique case (state)
      IDLE: begin
        gnt_nxt = 8'd0;
        idx_nxt = 3'd0;
        vld_nxt = 1'b0;
        if (en && any_req) begin
          owner_nxt = sel;
          gnt_nxt   = 8'b1 << sel;
          idx_nxt   = sel;
          vld_nxt   = 1'b1;
          state_nxt = GRANT;
        end
      end

      GRANT: begin
        if (!en) begin
          // Revoked by disable: pointer untouched so priority is preserved.
          gnt_nxt   = 8'd0;
          idx_nxt   = 3'd0;
          vld_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (!req[owner]) begin
          // Voluntary release: next requester in line gets top priority.
          gnt_nxt   = 8'd0;
          idx_nxt   = 3'd0;
          vld_nxt   = 1'b0;
          ptr_nxt   = owner + 3'd1;
          state_nxt = IDLE;
        end else if (hold_hit) begin
          // Hold budget exhausted while still requesting: force the owner off.
          gnt_nxt   = 8'd0;
          idx_nxt   = 3'd0;
          vld_nxt   = 1'b0;
          ptr_nxt   = owner + 3'd1;
          revoke_to = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pointer, owner and registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 3'd0;
      owner <= 3'd0;
      gnt_q <= 8'd0;
      idx_q <= 3'd0;
      vld_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      gnt_q <= gnt_nxt;
      idx_q <= idx_nxt;
      vld_q <= vld_nxt;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;

endmodule
